// File: rtl/ir_pkg.sv
// Shared definitions for the IR link.
// Holds the receive timing windows, the receive timeout, the transmitter's nominal phase
// lengths, the receive FSM state encoding and the error codes. All durations are in 100 MHz
// clock cycles.
package ir_pkg;

   // Duration counter width; 2^23 cycles covers the 25 ms timeout.
   localparam int unsigned DurW = 23;

   // Output word widths.
   localparam int unsigned D35HiW = 32;
   localparam int unsigned D35LoW = 3;
   localparam int unsigned D32W   = 32;
   localparam int unsigned ErrW   = 3;

   // Receive acceptance windows, inclusive.
   localparam int unsigned LeadMarkMin  = 800000;
   localparam int unsigned LeadMarkMax  = 1000000;
   localparam int unsigned LeadSpaceMin = 400000;
   localparam int unsigned LeadSpaceMax = 500000;
   localparam int unsigned BitMarkMin   = 40000;
   localparam int unsigned BitMarkMax   = 100000;
   localparam int unsigned ZeroSpaceMin = 20000;
   localparam int unsigned ZeroSpaceMax = 80000;
   localparam int unsigned OneSpaceMin  = 110000;
   localparam int unsigned OneSpaceMax  = 190000;
   localparam int unsigned ConnSpaceMin = 1800000;
   localparam int unsigned ConnSpaceMax = 2200000;

   // Any single phase longer than this while decoding aborts the frame.
   localparam int unsigned TimeoutCyc = 2500000;

   // Transmitter nominal phase lengths.
   localparam int unsigned TxLeadMarkCyc  = 900000;
   localparam int unsigned TxLeadSpaceCyc = 450000;
   localparam int unsigned TxBitMarkCyc   = 75000;
   localparam int unsigned TxZeroSpaceCyc = 45000;
   localparam int unsigned TxOneSpaceCyc  = 150000;
   localparam int unsigned TxConnSpaceCyc = 2000000;

   typedef enum logic [3:0] {
      StIdle,
      StLeadMark,
      StLeadSpace,
      StD35Mark,
      StD35Space,
      StConnMark,
      StConnSpace,
      StD32Mark,
      StD32Space,
      StStopMark
   } rx_state_e;

   typedef enum logic [2:0] {
      ErrNone      = 3'd0,
      ErrLeadMark  = 3'd1,
      ErrLeadSpace = 3'd2,
      ErrBitMark   = 3'd3,
      ErrBitSpace  = 3'd4,
      ErrConnSpace = 3'd5,
      ErrTimeout   = 3'd6
   } rx_err_e;

   function automatic logic in_window(logic [DurW-1:0] dur, int unsigned lo, int unsigned hi);
      return (32'(dur) >= lo) && (32'(dur) <= hi);
   endfunction

endpackage

// File: rtl/ir_rx_decoder_if.sv
// Decoded-frame bus between the IR receiver and the register block.
// master: the decoder, drives everything. slave: the consumer.
//   rx_data35_1 / rx_data35_0 : 35-bit word, bits 34..3 and 2..0
//   rx_data32                 : 32-bit second word
//   rx_valid                  : one-cycle pulse, data updated this cycle
//   rx_err / err_code         : one-cycle error pulse, code held until the next error
//   busy                      : a frame is being decoded
interface ir_rx_decoder_if;
   import ir_pkg::*;

   logic [D35HiW-1:0] rx_data35_1;
   logic [D35LoW-1:0] rx_data35_0;
   logic [D32W-1:0]   rx_data32;
   logic              rx_valid;
   logic              rx_err;
   logic [ErrW-1:0]   err_code;
   logic              busy;

   modport master (
      output rx_data35_1, rx_data35_0, rx_data32, rx_valid, rx_err, err_code, busy
   );

   modport slave (
      input rx_data35_1, rx_data35_0, rx_data32, rx_valid, rx_err, err_code, busy
   );

endinterface

// File: rtl/ir_rx_filter.sv
// IR input conditioning: polarity fix, 2-FF synchroniser, glitch filter and edge strobes.
//   clk        : system clock
//   rst        : synchronous reset, active-low
//   ir_in      : raw asynchronous receiver output
//   mark_start : one-cycle strobe, filtered level went space -> mark
//   mark_end   : one-cycle strobe, filtered level went mark -> space
// Both edges see the same delay (2 sync + FILT_CYC samples + 1 strobe register), so the gap
// between strobes equals the on-air phase length.
module ir_rx_filter
   import ir_pkg::*;
#(
   parameter int unsigned FILT_CYC   = 50,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic ir_in,
   output logic mark_start,
   output logic mark_end
);

   localparam int unsigned CntW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(FILT_CYC - 1);

   logic            raw_mark;
   logic            sync1_q;
   logic            sync2_q;
   logic            level_q;
   logic            level_d1_q;
   logic [CntW-1:0] cnt_q;

   // 1 = carrier present, whatever the receiver polarity.
   assign raw_mark = ACTIVE_LOW ? ~ir_in : ir_in;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         level_q    <= 1'b0;
         level_d1_q <= 1'b0;
         cnt_q      <= '0;
         mark_start <= 1'b0;
         mark_end   <= 1'b0;
      end else begin
         sync1_q <= raw_mark;
         sync2_q <= sync1_q;
         // Count consecutive samples disagreeing with the accepted level; flip on the last.
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntLast) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         level_d1_q <= level_q;
         mark_start <= level_q & ~level_d1_q;
         mark_end   <= ~level_q & level_d1_q;
      end
   end

endmodule

// File: rtl/ir_rx_decoder.sv
// IR receive decoder: turns the demodulated receiver output into the 35-bit and 32-bit
// command words of one air-conditioner frame.
//   clk   : 100 MHz system clock
//   rst   : synchronous reset, active-low
//   ir_in : demodulated IR receiver output, asynchronous
//   rx    : decoded-frame bus (data words, valid/error pulses, err_code, busy)
// TIME_DIV divides every timing window and the timeout; 1 gives real-time operation.
module ir_rx_decoder
   import ir_pkg::*;
#(
   parameter int unsigned FILT_CYC   = 50,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned TIME_DIV   = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ir_in,
   ir_rx_decoder_if.master rx
);

   localparam int unsigned LmMin = LeadMarkMin / TIME_DIV;
   localparam int unsigned LmMax = LeadMarkMax / TIME_DIV;
   localparam int unsigned LsMin = LeadSpaceMin / TIME_DIV;
   localparam int unsigned LsMax = LeadSpaceMax / TIME_DIV;
   localparam int unsigned BmMin = BitMarkMin / TIME_DIV;
   localparam int unsigned BmMax = BitMarkMax / TIME_DIV;
   localparam int unsigned ZsMin = ZeroSpaceMin / TIME_DIV;
   localparam int unsigned ZsMax = ZeroSpaceMax / TIME_DIV;
   localparam int unsigned OsMin = OneSpaceMin / TIME_DIV;
   localparam int unsigned OsMax = OneSpaceMax / TIME_DIV;
   localparam int unsigned CsMin = ConnSpaceMin / TIME_DIV;
   localparam int unsigned CsMax = ConnSpaceMax / TIME_DIV;
   // Compare against one less so the error pulse rises a full timeout after the strobe.
   localparam logic [DurW-1:0] ToLast = DurW'(TimeoutCyc / TIME_DIV - 1);

   logic            mark_start;
   logic            mark_end;
   logic            edge_seen;
   logic [DurW-1:0] dur_q;
   rx_state_e       state_q;
   logic [5:0]      bitcnt_q;
   logic [34:0]     sh35_q;
   logic [31:0]     sh32_q;

   logic lm_ok, ls_ok, bm_ok, zero_ok, one_ok, space_ok, cs_ok, timeout;

   ir_rx_filter #(
      .FILT_CYC  (FILT_CYC),
      .ACTIVE_LOW(ACTIVE_LOW)
   ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .ir_in     (ir_in),
      .mark_start(mark_start),
      .mark_end  (mark_end)
   );

   assign edge_seen = mark_start | mark_end;

   // Restarts at 1 so that, at the next strobe, dur_q equals the phase length in cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dur_q <= '0;
      end else if (edge_seen) begin
         dur_q <= DurW'(1);
      end else if (dur_q != '1) begin
         dur_q <= dur_q + 1'b1;
      end
   end

   assign lm_ok    = in_window(dur_q, LmMin, LmMax);
   assign ls_ok    = in_window(dur_q, LsMin, LsMax);
   assign bm_ok    = in_window(dur_q, BmMin, BmMax);
   assign zero_ok  = in_window(dur_q, ZsMin, ZsMax);
   assign one_ok   = in_window(dur_q, OsMin, OsMax);
   assign cs_ok    = in_window(dur_q, CsMin, CsMax);
   assign space_ok = zero_ok | one_ok;
   // An edge in the same cycle wins; its window check will reject the long phase anyway.
   assign timeout  = (state_q != StIdle) && !edge_seen && (dur_q == ToLast);

   assign rx.busy = (state_q != StIdle);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= StIdle;
         bitcnt_q       <= '0;
         sh35_q         <= '0;
         sh32_q         <= '0;
         rx.rx_data35_1 <= '0;
         rx.rx_data35_0 <= '0;
         rx.rx_data32   <= '0;
         rx.rx_valid    <= 1'b0;
         rx.rx_err      <= 1'b0;
         rx.err_code    <= '0;
      end else begin
         rx.rx_valid <= 1'b0;
         rx.rx_err   <= 1'b0;
         if (timeout) begin
            state_q     <= StIdle;
            rx.rx_err   <= 1'b1;
            rx.err_code <= ErrTimeout;
         end else begin
            case (state_q)
               StIdle: begin
                  if (mark_start) state_q <= StLeadMark;
               end
               StLeadMark: begin
                  if (mark_end) begin
                     if (lm_ok) begin
                        state_q <= StLeadSpace;
                     end else begin
                        state_q     <= StIdle;
                        rx.rx_err   <= 1'b1;
                        rx.err_code <= ErrLeadMark;
                     end
                  end
               end
               StLeadSpace: begin
                  if (mark_start) begin
                     if (ls_ok) begin
                        state_q  <= StD35Mark;
                        bitcnt_q <= '0;
                        sh35_q   <= '0;
                     end else begin
                        state_q     <= StIdle;
                        rx.rx_err   <= 1'b1;
                        rx.err_code <= ErrLeadSpace;
                     end
                  end
               end
               StD35Mark, StConnMark, StD32Mark, StStopMark: begin
                  if (mark_end) begin
                     if (!bm_ok) begin
                        state_q     <= StIdle;
                        rx.rx_err   <= 1'b1;
                        rx.err_code <= ErrBitMark;
                     end else if (state_q == StD35Mark) begin
                        state_q <= StD35Space;
                     end else if (state_q == StConnMark) begin
                        state_q <= StConnSpace;
                     end else if (state_q == StD32Mark) begin
                        state_q <= StD32Space;
                     end else begin
                        state_q        <= StIdle;
                        rx.rx_valid    <= 1'b1;
                        rx.rx_data35_1 <= sh35_q[34:3];
                        rx.rx_data35_0 <= sh35_q[2:0];
                        rx.rx_data32   <= sh32_q;
                     end
                  end
               end
               StD35Space: begin
                  if (mark_start) begin
                     if (!space_ok) begin
                        state_q     <= StIdle;
                        rx.rx_err   <= 1'b1;
                        rx.err_code <= ErrBitSpace;
                     end else begin
                        sh35_q   <= {sh35_q[33:0], one_ok};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        state_q  <= (bitcnt_q == 6'd34) ? StConnMark : StD35Mark;
                     end
                  end
               end
               StConnSpace: begin
                  if (mark_start) begin
                     if (cs_ok) begin
                        state_q  <= StD32Mark;
                        bitcnt_q <= '0;
                        sh32_q   <= '0;
                     end else begin
                        state_q     <= StIdle;
                        rx.rx_err   <= 1'b1;
                        rx.err_code <= ErrConnSpace;
                     end
                  end
               end
               StD32Space: begin
                  if (mark_start) begin
                     if (!space_ok) begin
                        state_q     <= StIdle;
                        rx.rx_err   <= 1'b1;
                        rx.err_code <= ErrBitSpace;
                     end else begin
                        sh32_q   <= {sh32_q[30:0], one_ok};
                        bitcnt_q <= bitcnt_q + 1'b1;
                        state_q  <= (bitcnt_q == 6'd31) ? StStopMark : StD32Mark;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: doc/ir_rx_decoder.md
Name: ir_rx_decoder

Overview:
- Receive side of the air-conditioner IR link: decodes the demodulated IR receiver output back into the 35-bit + 32-bit command words that the IR transmitter sends.
- Sits between the board IR receiver pin and the AXI register block, which reads the decoded words.
- Output word layout matches the transmitter's input layout, so decoded frames can be looped straight back for test.
- Clock is 100 MHz; all timing constants are in clock cycles at that rate.

Parameters:
- FILT_CYC, 50, cycles the synchronised input must be stable before a level change is accepted (0.5 us).
- ACTIVE_LOW, 1, 1 = ir_in low means carrier present (mark).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous reset, active-low
- ir_in  in  1  demodulated IR receiver output, asynchronous
- rx_data35_1  out  32  frame bits 34..3
- rx_data35_0  out  3  frame bits 2..0
- rx_data32  out  32  second-frame word
- rx_valid  out  1  one-cycle pulse; data outputs updated this cycle
- rx_err  out  1  one-cycle pulse on a decode error
- err_code  out  3  reason for the last error; held until the next error
- busy  out  1  high while a frame is being decoded (state not IDLE)

Behaviour:
- Reset: the one clock is clk; rst is synchronous and active-low. While rst is low, every output is 0 and the FSM goes to IDLE. Reset mid-frame discards partial data.
- Input path:
  - 2-FF synchroniser, then the glitch filter.
  - The filtered level changes only after FILT_CYC consecutive equal samples.
  - mark_start / mark_end are one-cycle strobes taken from filtered edges.
- Duration counter:
  - 23 bits, cleared on every filtered edge, saturating.
  - At the edge, the value measured is the length of the phase just ended.
- Windows, in cycles:
  - Lead mark: 800000..1000000.
  - Lead space: 400000..500000.
  - Bit mark: 40000..100000.
  - Zero space: 20000..80000.
  - One space: 110000..190000.
  - Connect space: 1800000..2200000.
- On-air frame:
  - Lead 9 ms mark + 4.5 ms space.
  - 35 bits, MSB (bit 34) first. Each bit is a 750 us mark, then a 450 us space (0) or 1500 us space (1).
  - Connect: 750 us mark + 20 ms space.
  - 32 bits, MSB first.
  - Stop: 750 us mark.
- FSM states and transitions:
  - IDLE: on mark_start, go to LEAD_MARK.
  - LEAD_MARK: on mark_end, go to LEAD_SPACE if in window, else error 1.
  - LEAD_SPACE: on mark_start, go to D35_MARK with bitcnt=0 if in window, else error 2.
  - D35_MARK, CONN_MARK, D32_MARK, STOP_MARK: on mark_end, go to the matching SPACE state if in the bit-mark window, else error 3.
  - D35_SPACE: on mark_start, classify 0/1 (neither window gives error 4) and shift left into sh35. bitcnt++. After bit 35, next state is CONN_MARK; otherwise D35_MARK.
  - CONN_SPACE: on mark_start, go to D32_MARK with bitcnt=0 if in window, else error 5.
  - D32_SPACE: classify as in D35_SPACE, shift into sh32. After bit 32, next state is STOP_MARK.
  - STOP_MARK end, in window: rx_valid=1 next cycle. Outputs load rx_data35_1=sh35[34:3], rx_data35_0=sh35[2:0], rx_data32=sh32. Go to IDLE.
- Timeout: in any non-IDLE state, a duration counter reaching 2500000 (25 ms) gives error 6.
- Error handling:
  - rx_err pulses for one cycle and err_code is loaded.
  - Go to IDLE.
  - Data outputs keep the last good frame.
  - The edge that caused the error is consumed. Decoding resumes on the next mark_start.
- Latency: rx_valid rises exactly 2 + FILT_CYC + 2 clocks after ir_in goes inactive at the end of the stop mark.
- Simultaneous events: error and valid are mutually exclusive. Edges are never dropped, because the filter holds state between FILT_CYC windows.

Decomposition:
- Package ir_pkg holds:
  - window min/max constants and the 25 ms timeout;
  - FSM state enum;
  - err_code values: 1 lead mark, 2 lead space, 3 bit mark, 4 bit space, 5 connect space, 6 timeout.
- The transmitter's timing constants move into the same package.
- One sub-module, ir_rx_filter: synchroniser, glitch filter and edge strobes.

Test Plan:
- Nominal frame, data35=35'b10000010000100000000010000001010010, data32=32'h08040006 -> one rx_valid pulse; rx_data35_1=32'h8210040A, rx_data35_0=3'b010, rx_data32=32'h08040006; rx_err never asserts.
- Second frame with data35_1=32'h9210040A, data32=32'h08040007, all phases stretched +10% -> rx_valid; outputs update to the new values.
- Lead mark of 6 ms -> rx_err with err_code=1; no rx_valid; outputs keep the previous frame; busy returns to 0.
- Bit 5 space of 1000 us -> rx_err with err_code=4. A following nominal frame then decodes correctly.
- Stop mark omitted (silence after bit 32's mark) -> rx_err with err_code=6 exactly 2500000 cycles after the filtered mark_end.
- 200 ns low glitch while IDLE -> busy stays 0. rst low for 1 cycle mid-frame -> all outputs 0; the next nominal frame decodes.
